// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding, default widths and
// address-split helpers for the CPU-to-Avalon word bridge.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_RDW  = 2'd3
  } state_t;

  localparam int DEF_RAM_ADDR_W  = 26;
  localparam int DEF_RAM_DATA_W  = 128;
  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 1023;

  function automatic int off_bits(input int ram_data_w);
    return $clog2(ram_data_w / 8);
  endfunction

  function automatic int wb_bits(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/avl_lane_mux.sv
// avl_lane_mux: places a CPU word into its lane of a wide beat
// (replicated data, shifted byteenable) and extracts a lane on reads.
module avl_lane_mux
  import mem_pkg::*;
#(
  parameter int RAM_DATA_W = DEF_RAM_DATA_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LW         = 2
) (
  input  logic [LW-1:0]           wr_lane,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [DATA_W/8-1:0]     be,
  input  logic [LW-1:0]           rd_lane,
  input  logic [RAM_DATA_W-1:0]   rbeat,
  output logic [RAM_DATA_W-1:0]   wbeat,
  output logic [RAM_DATA_W/8-1:0] wbe,
  output logic [DATA_W-1:0]       rdata
);

  localparam int LANES = RAM_DATA_W / DATA_W;
  localparam int BEW   = DATA_W / 8;
  localparam int RBEW  = RAM_DATA_W / 8;

  always_comb begin
    wbeat = {LANES{wdata}};
    wbe   = RBEW'(be) << (int'(wr_lane) * BEW);
    rdata = rbeat[int'(rd_lane) * DATA_W +: DATA_W];
  end

endmodule

// File: rtl/avl_word_bridge.sv
// avl_word_bridge: single-outstanding CPU word port to wide Avalon-MM.
// Optional read-response timeout: define READ_TIMEOUT_EN.
module avl_word_bridge
  import mem_pkg::*;
#(
  parameter int RAM_ADDR_W  = DEF_RAM_ADDR_W,
  parameter int RAM_DATA_W  = DEF_RAM_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    iCLK,
  input  logic                    iRST,
  input  logic                    mem_req,
  input  logic                    mem_we,
  input  logic [ADDR_W-1:0]       mem_addr,
  input  logic [DATA_W/8-1:0]     mem_be,
  input  logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_busy,
  output logic                    mem_done,
  output logic [DATA_W-1:0]       mem_rdata,
  output logic                    mem_err,
  input  logic                    avl_wait,
  input  logic                    avl_readdatavalid,
  input  logic [RAM_DATA_W-1:0]   avl_readdata,
  output logic [RAM_ADDR_W-1:0]   avl_address,
  output logic                    avl_read,
  output logic                    avl_write,
  output logic [RAM_DATA_W-1:0]   avl_writedata,
  output logic [RAM_DATA_W/8-1:0] avl_byteenable
);

  localparam int OFF   = off_bits(RAM_DATA_W);
  localparam int WB    = wb_bits(DATA_W);
  localparam int LANES = RAM_DATA_W / DATA_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  state_t state_q, state_d;

  logic                    accept;
  logic                    done_d;
  logic                    rd_load;
  logic [LW-1:0]           lane_in;
  logic [LW-1:0]           lane_q;
  logic [RAM_DATA_W-1:0]   wbeat;
  logic [RAM_DATA_W/8-1:0] wbe;
  logic [DATA_W-1:0]       rd_word;

  if (LANES > 1) begin : g_lane
    assign lane_in = mem_addr[OFF-1:WB];
  end else begin : g_nolane
    assign lane_in = '0;
  end

  avl_lane_mux #(
    .RAM_DATA_W(RAM_DATA_W),
    .DATA_W    (DATA_W),
    .LW        (LW)
  ) u_mux (
    .wr_lane(lane_in),
    .wdata  (mem_wdata),
    .be     (mem_be),
    .rd_lane(lane_q),
    .rbeat  (avl_readdata),
    .wbeat  (wbeat),
    .wbe    (wbe),
    .rdata  (rd_word)
  );

  // A done pulse still marks the request as finishing.
  assign accept = (state_q == S_IDLE) && mem_req && !mem_done;

`ifdef READ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;
  logic          to_hit;
  logic          err_d;

  assign to_hit = ((state_q == S_RD) || (state_q == S_RDW))
                  && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_q   <= '0;
      mem_err <= 1'b0;
    end else begin
      mem_err <= err_d;
      if (accept)
        cnt_q <= '0;
      else if ((state_q == S_RD) || (state_q == S_RDW))
        cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{32'(TIMEOUT_CYC)};
  assign mem_err    = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^mem_addr;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    rd_load = 1'b0;
`ifdef READ_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept)
          state_d = mem_we ? S_WR : S_RD;
      end
      S_WR: begin
        if (!avl_wait) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_RD: begin
        if (!avl_wait)
          state_d = S_RDW;
`ifdef READ_TIMEOUT_EN
        if (to_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
`endif
      end
      S_RDW: begin
        if (avl_readdatavalid) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          rd_load = 1'b1;
        end
`ifdef READ_TIMEOUT_EN
        else if (to_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      mem_busy       <= 1'b0;
      mem_done       <= 1'b0;
      mem_rdata      <= '0;
      avl_address    <= '0;
      avl_read       <= 1'b0;
      avl_write      <= 1'b0;
      avl_writedata  <= '0;
      avl_byteenable <= '0;
      lane_q         <= '0;
    end else begin
      mem_done <= done_d;
      if ((state_q != S_IDLE) && (state_d != state_q)) begin
        avl_write <= 1'b0;
        avl_read  <= 1'b0;
      end
      if (done_d)
        mem_busy <= 1'b0;
      if (rd_load)
        mem_rdata <= rd_word;
      if (accept) begin
        mem_busy       <= 1'b1;
        avl_address    <= mem_addr[OFF+RAM_ADDR_W-1:OFF];
        lane_q         <= lane_in;
        avl_writedata  <= wbeat;
        avl_byteenable <= mem_we ? wbe : '1;
        avl_write      <= mem_we;
        avl_read       <= !mem_we;
      end
    end
  end

endmodule
